// File: rtl/uart_receive.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling, one-cycle
// valid / framing-error strobes. Counterpart of the board's transmitter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_sync low
// S_START | timing to mid-start-bit, revalidating the low level
// S_DATA  | sampling 8 data bits, LSB first, one per PERIOD
// S_STOP  | sampling the stop bit; deliver byte or flag framing error
// S_BRK   | stop bit was low; wait for the line to return high
module uart_receive #(
   parameter int INPUT_CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE        = 9600
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       rx_wire_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       framing_error_out,
   output logic       busy_out
);

   localparam int PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
   localparam int HALF   = PERIOD / 2;
   localparam int CW     = $clog2(PERIOD);

   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(PERIOD - 1);

   if (PERIOD < 4) begin : g_period_check
      $error("uart_receive: INPUT_CLOCK_FREQ / BAUD_RATE must be at least 4");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BRK
   } state_t;

   state_t        state_q, state_d;
   logic          s1_q, rx_sync_q;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    index_q, index_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      count_d = '0;
      index_d = index_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_sync_q) state_d = S_START;
         end
         S_START: begin
            if (count_q == CNT_HALF) begin
               // A start bit that is already high again at its midpoint is a glitch.
               state_d = rx_sync_q ? S_IDLE : S_DATA;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         S_DATA: begin
            if (count_q == CNT_FULL) begin
               shift_d[index_q] = rx_sync_q;
               if (index_q == 3'd7) begin
                  index_d = 3'd0;
                  state_d = S_STOP;
               end else begin
                  index_d = index_q + 3'd1;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         S_STOP: begin
            if (count_q == CNT_FULL) begin
               if (rx_sync_q) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = S_BRK;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         S_BRK: begin
            if (rx_sync_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_q      <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= S_IDLE;
         count_q   <= '0;
         index_q   <= 3'd0;
         shift_q   <= 8'h00;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         s1_q      <= rx_wire_in;
         rx_sync_q <= s1_q;
         state_q   <= state_d;
         count_q   <= count_d;
         index_q   <= index_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
         busy_q    <= busy_d;
      end
   end

   assign data_out          = data_q;
   assign valid_out         = valid_q;
   assign framing_error_out = ferr_q;
   assign busy_out          = busy_q;

endmodule

// File: tb/tb_uart_receive.sv
// Bench for uart_receive at PERIOD=16: frames are driven bit by bit and
// received bytes are matched against a queue of expected bytes.
module tb_uart_receive;

   localparam int FREQ   = 16;
   localparam int BAUD   = 1;
   localparam int PERIOD = 16;
   localparam int HALF   = 8;

   logic       clk_in = 1'b0;
   logic       rst_n_in;
   logic       rx_wire_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       framing_error_out;
   logic       busy_out;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int last_valid_cyc = 0;
   int prev_valid_cyc = 0;
   logic busy_at_valid = 1'b1;
   logic [7:0] exp_q[$];

   uart_receive #(
      .INPUT_CLOCK_FREQ(FREQ),
      .BAUD_RATE(BAUD)
   ) dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .rx_wire_in(rx_wire_in),
      .data_out(data_out),
      .valid_out(valid_out),
      .framing_error_out(framing_error_out),
      .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   // Advance to the next falling edge and act as the output monitor / scoreboard.
   task automatic tick();
      logic [7:0] e;
      @(negedge clk_in);
      cyc++;
      if (valid_out || framing_error_out) begin
         checks++;
         if (valid_out && framing_error_out) begin
            errors++;
            $display("FAIL exclusive: valid_out and framing_error_out both 1 at cycle %0d", cyc);
         end
      end
      if (valid_out) begin
         valid_cnt++;
         prev_valid_cyc = last_valid_cyc;
         last_valid_cyc = cyc;
         busy_at_valid  = busy_out;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got byte %02h, expected no byte", data_out);
         end else begin
            e = exp_q.pop_front();
            if (data_out !== e) begin
               errors++;
               $display("FAIL scoreboard: got byte %02h, expected %02h", data_out, e);
            end
         end
      end
      if (framing_error_out) ferr_cnt++;
   endtask

   task automatic drive_bit(input logic v);
      rx_wire_in = v;
      repeat (PERIOD) tick();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic idle(input int n);
      rx_wire_in = 1'b1;
      repeat (n) tick();
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL timeout: %0d expected bytes never received", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst_n_in   = 1'b0;
      rx_wire_in = 1'b1;
      for (int i = 0; i < 10; i++) begin
         rx_wire_in = ~rx_wire_in;
         tick();
      end
      checks += 4;
      if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h, expected 00", data_out); end
      if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid_out); end
      if (framing_error_out !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, expected 0", framing_error_out); end
      if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_out); end
      rx_wire_in = 1'b1;
      rst_n_in   = 1'b1;
      idle(5);
   endtask

   task automatic test_first_frame();
      int c0, v0;
      v0 = valid_cnt;
      c0 = cyc;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      idle(4);
      wait_empty(50);
      checks += 4;
      if (valid_cnt - v0 != 1) begin errors++; $display("FAIL a5_count: got %0d pulses, expected 1", valid_cnt - v0); end
      // Line set just after a falling edge: 2 sync cycles + 1 to reach E0's edge.
      if (last_valid_cyc - c0 != HALF + 9 * PERIOD + 3) begin
         errors++;
         $display("FAIL a5_latency: got %0d, expected %0d", last_valid_cyc - c0, HALF + 9 * PERIOD + 3);
      end
      if (busy_at_valid !== 1'b0) begin errors++; $display("FAIL a5_busy: got %b with valid, expected 0", busy_at_valid); end
      if (data_out !== 8'hA5) begin errors++; $display("FAIL a5_data: got %02h, expected a5", data_out); end
   endtask

   task automatic test_glitch();
      int c, v0, f0, fall;
      logic saw;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      saw = 1'b0;
      fall = -1;
      c = cyc;
      rx_wire_in = 1'b0;
      repeat (4) begin
         tick();
         if (busy_out) saw = 1'b1;
      end
      rx_wire_in = 1'b1;
      repeat (30) begin
         tick();
         if (busy_out) saw = 1'b1;
         if (saw && !busy_out && fall < 0) fall = cyc;
      end
      checks += 4;
      if (saw !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise: got %b, expected 1", saw); end
      if (fall < 0 || fall - c > HALF + 3) begin
         errors++;
         $display("FAIL glitch_busy_fall: got %0d cycles, expected at most %0d", fall - c, HALF + 3);
      end
      if (valid_cnt != v0) begin errors++; $display("FAIL glitch_valid: got %0d pulses, expected 0", valid_cnt - v0); end
      if (ferr_cnt != f0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses, expected 0", ferr_cnt - f0); end
   endtask

   task automatic test_framing_error();
      int v0, f0, h, fall;
      logic dropped;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      dropped = 1'b0;
      fall = -1;
      send_frame(8'h3C, 1'b0);
      repeat (40) begin
         tick();
         if (!busy_out) dropped = 1'b1;
      end
      h = cyc;
      rx_wire_in = 1'b1;
      repeat (20) begin
         tick();
         if (!busy_out && fall < 0) fall = cyc;
      end
      checks += 5;
      if (ferr_cnt - f0 != 1) begin errors++; $display("FAIL ferr_count: got %0d pulses, expected 1", ferr_cnt - f0); end
      if (valid_cnt != v0) begin errors++; $display("FAIL ferr_valid: got %0d pulses, expected 0", valid_cnt - v0); end
      if (data_out !== 8'hA5) begin errors++; $display("FAIL ferr_data: got %02h, expected a5", data_out); end
      if (dropped !== 1'b0) begin errors++; $display("FAIL ferr_busy_hold: busy dropped during break, expected held"); end
      if (fall - h != 3) begin errors++; $display("FAIL ferr_busy_fall: got %0d cycles, expected 3", fall - h); end
      idle(4);
      v0 = valid_cnt;
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      idle(4);
      wait_empty(50);
      checks += 2;
      if (valid_cnt - v0 != 1) begin errors++; $display("FAIL after_ferr_count: got %0d, expected 1", valid_cnt - v0); end
      if (data_out !== 8'h5A) begin errors++; $display("FAIL after_ferr_data: got %02h, expected 5a", data_out); end
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = valid_cnt;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(4);
      wait_empty(50);
      checks += 3;
      if (valid_cnt - v0 != 2) begin errors++; $display("FAIL b2b_count: got %0d, expected 2", valid_cnt - v0); end
      if (last_valid_cyc - prev_valid_cyc != 10 * PERIOD) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d, expected %0d", last_valid_cyc - prev_valid_cyc, 10 * PERIOD);
      end
      if (data_out !== 8'hFF) begin errors++; $display("FAIL b2b_data: got %02h, expected ff", data_out); end
   endtask

   task automatic test_reset_mid_frame();
      int v0;
      v0 = valid_cnt;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rx_wire_in = 1'b0;
      repeat (8) tick();
      rst_n_in = 1'b0;
      #1;
      checks += 4;
      if (data_out !== 8'h00) begin errors++; $display("FAIL midrst_data: got %02h, expected 00", data_out); end
      if (busy_out !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, expected 0", busy_out); end
      if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, expected 0", valid_out); end
      if (framing_error_out !== 1'b0) begin errors++; $display("FAIL midrst_ferr: got %b, expected 0", framing_error_out); end
      repeat (3) tick();
      rx_wire_in = 1'b1;
      repeat (3) tick();
      rst_n_in = 1'b1;
      idle(40);
      checks++;
      if (valid_cnt != v0) begin errors++; $display("FAIL midrst_novalid: got %0d pulses, expected 0", valid_cnt - v0); end
      exp_q.push_back(8'h42);
      send_frame(8'h42, 1'b1);
      idle(4);
      wait_empty(50);
      checks++;
      if (data_out !== 8'h42) begin errors++; $display("FAIL midrst_data42: got %02h, expected 42", data_out); end
   endtask

   task automatic test_random();
      int v0, f0;
      logic [7:0] b;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      for (int i = 0; i < 200; i++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         send_frame(b, 1'b1);
         idle(int'($urandom_range(0, 3)) * PERIOD);
      end
      idle(4);
      wait_empty(200);
      checks += 2;
      if (valid_cnt - v0 != 200) begin errors++; $display("FAIL rand_count: got %0d, expected 200", valid_cnt - v0); end
      if (ferr_cnt != f0) begin errors++; $display("FAIL rand_ferr: got %0d pulses, expected 0", ferr_cnt - f0); end
   endtask

   initial begin
      rst_n_in   = 1'b0;
      rx_wire_in = 1'b1;
      test_reset();
      test_first_frame();
      test_glitch();
      test_framing_error();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
